// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text renderer.
// Colours are packed {Blue,Green,Red}, 8 bits each; glyphs are 5x7 bitmaps
// with bit[gy*5+gx] set for a lit dot (gy=0 top row, gx=0 left column).
package vga_text_pkg;

   typedef logic [23:0] colour_t;
   typedef logic [34:0] glyph_t;

   localparam colour_t BLACK  = 24'h000000;
   localparam colour_t BLUE   = 24'hFF0000;
   localparam colour_t GREEN  = 24'h00FF00;
   localparam colour_t RED    = 24'h0000FF;
   localparam colour_t WHITE  = 24'hFFFFFF;
   localparam colour_t YELLOW = 24'h00FFFF;
   localparam colour_t CYAN   = 24'hFFFF00;
   localparam colour_t PINK   = 24'hFF00FF;

   typedef enum logic [7:0] {
      GLY_BLANK = 8'd0,
      GLY_BLOCK = 8'd1,
      GLY_A     = 8'd2,
      GLY_B     = 8'd3
   } glyph_code_e;

   // Rows are given top to bottom; within a row the LSB is the leftmost dot,
   // so the binary literals read mirror-imaged.
   function automatic glyph_t mk_glyph(input logic [4:0] r0, r1, r2, r3, r4, r5, r6);
      return {r6, r5, r4, r3, r2, r1, r0};
   endfunction

endpackage

// File: rtl/vga_text_renderer_if.sv
// Bus between the timing generator / character writer and the text renderer.
// master: drives pixel position, frame pulse and char-RAM writes; reads colour.
// slave:  the renderer, consuming the inputs and driving the registered colour.
interface vga_text_renderer_if #(
   parameter int COLS = 16,
   parameter int ROWS = 2
);
   localparam int AW = $clog2(COLS * ROWS);
   localparam int CW = $clog2(COLS * ROWS + 1);

   logic [9:0]    i_x_pos;
   logic [9:0]    i_y_pos;
   logic          i_frame_start;
   logic          i_wr_en;
   logic [AW-1:0] i_wr_addr;
   logic [7:0]    i_wr_data;
   logic [CW-1:0] i_word_cnt;
   logic          i_commit;
   logic [7:0]    o_Blue;
   logic [7:0]    o_Green;
   logic [7:0]    o_Red;

   modport master (
      output i_x_pos, i_y_pos, i_frame_start, i_wr_en, i_wr_addr, i_wr_data, i_word_cnt, i_commit,
      input  o_Blue, o_Green, o_Red
   );

   modport slave (
      input  i_x_pos, i_y_pos, i_frame_start, i_wr_en, i_wr_addr, i_wr_data, i_word_cnt, i_commit,
      output o_Blue, o_Green, o_Red
   );
endinterface

// File: rtl/vga_glyph_rom.sv
// Glyph ROM: character code -> 5x7 bitmap, purely combinational.
// Latency 0; the caller registers the result.
// No backpressure. Ports: i_code (8b glyph code), o_glyph (35b bitmap).
module vga_glyph_rom
   import vga_text_pkg::*;
(
   input  logic [7:0] i_code,
   output glyph_t     o_glyph
);
   always_comb begin
      o_glyph = '0;
      case (i_code)
         GLY_BLOCK: o_glyph = '1;
         GLY_A:     o_glyph = mk_glyph(5'b00000, 5'b00100, 5'b01010, 5'b10001,
                                       5'b11111, 5'b10001, 5'b10001);
         GLY_B:     o_glyph = mk_glyph(5'b01111, 5'b10001, 5'b10001, 5'b01111,
                                       5'b10001, 5'b10001, 5'b01111);
         default:   o_glyph = '0;
      endcase
   end
endmodule

// File: rtl/vga_text_renderer.sv
// Text renderer: ROWS x COLS grid of 5x7 dot glyphs from a double-buffered char RAM.
// Latency 3 cycles from x/y to o_* colour; every cycle advances, no stall.
// No backpressure: writes/commits are accepted every cycle; swaps happen at frame_start.
// Ports: i_clk, i_rst (async high); bus (slave): x/y, frame_start, wr_en/addr/data,
// word_cnt, commit in; o_Blue/o_Green/o_Red out. Optional cursor: CURSOR_BLINK_EN.
module vga_text_renderer
   import vga_text_pkg::*;
#(
   parameter int COLS         = 16,
   parameter int ROWS         = 2,
   parameter int PIXEL_DIST   = 10,
   parameter int PIXEL_LEN    = 8,
   parameter int CHAR_GAP     = 10,
   parameter int OFFSET_X     = 40,
   parameter int OFFSET_Y     = 30,
   parameter int BLINK_FRAMES = 30
) (
   input logic                i_clk,
   input logic                i_rst,
   vga_text_renderer_if.slave bus
);
   localparam int CELLS  = COLS * ROWS;
   localparam int AW     = $clog2(CELLS);
   localparam int CW     = $clog2(CELLS + 1);
   localparam int COLW   = $clog2(COLS + 1);
   localparam int ROWW   = $clog2(ROWS + 1);
   localparam int CELL_W = 5 * PIXEL_DIST + CHAR_GAP;
   localparam int CELL_H = 7 * PIXEL_DIST + CHAR_GAP;

   // Bank control and character RAM
   logic          bank_sel_q, bank_sel_d;
   logic          commit_pend_q, commit_pend_d;
   logic [CW-1:0] active_cnt_q, active_cnt_d;
   logic [7:0]    mem_q [2][CELLS];
   logic [7:0]    mem_d [2][CELLS];
   logic          swap;

   always_comb begin
      swap          = bus.i_frame_start && (commit_pend_q || bus.i_commit);
      bank_sel_d    = bank_sel_q ^ swap;
      commit_pend_d = !swap && (commit_pend_q || bus.i_commit);
      active_cnt_d  = active_cnt_q;
      if (swap)
         active_cnt_d = (32'(bus.i_word_cnt) > 32'(CELLS)) ? CW'(CELLS) : bus.i_word_cnt;
      mem_d = mem_q;
      // Writes target the pre-swap shadow even when a swap fires this cycle,
      // so the new content is what becomes visible.
      if (bus.i_wr_en && (32'(bus.i_wr_addr) < 32'(CELLS)))
         mem_d[~bank_sel_q][bus.i_wr_addr] = bus.i_wr_data;
   end

   // Cursor blink phase
   logic cursor_ph;
`ifdef CURSOR_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic          blink_ph_q, blink_ph_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      blink_ph_d  = blink_ph_q;
      if (bus.i_frame_start) begin
         if (32'(frame_cnt_q) == 32'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         frame_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         blink_ph_q  <= blink_ph_d;
      end
   end
   assign cursor_ph = blink_ph_q;
`else
   assign cursor_ph = 1'b0;
`endif

   // S1: cell column/row by comparator chain, cell-local offsets
   logic [9:0]    dx, dy, cx, cy;
   logic [COLW-1:0] col;
   logic [ROWW-1:0] row;
   logic [CW-1:0] idx;
   logic          in_region, in_text_d, cursor_d;

   always_comb begin
      dx  = bus.i_x_pos - 10'(OFFSET_X);
      dy  = bus.i_y_pos - 10'(OFFSET_Y);
      col = '0;
      cx  = dx;
      for (int k = 1; k <= COLS; k++)
         if (int'(dx) >= k * CELL_W) begin
            col = COLW'(k);
            cx  = dx - 10'(k * CELL_W);
         end
      row = '0;
      cy  = dy;
      for (int k = 1; k <= ROWS; k++)
         if (int'(dy) >= k * CELL_H) begin
            row = ROWW'(k);
            cy  = dy - 10'(k * CELL_H);
         end
      in_region = (bus.i_x_pos >= 10'(OFFSET_X)) && (bus.i_y_pos >= 10'(OFFSET_Y)) &&
                  (32'(col) < 32'(COLS)) && (32'(row) < 32'(ROWS));
      // Only meaningful inside the grid, where it cannot overflow CW bits.
      idx       = CW'(row) * CW'(COLS) + CW'(col);
      in_text_d = in_region && (idx < active_cnt_q);
`ifdef CURSOR_BLINK_EN
      cursor_d  = in_region && (idx == active_cnt_q) && (active_cnt_q < CW'(CELLS));
`else
      cursor_d  = 1'b0;
`endif
   end

   logic          s1_text_q, s1_cursor_q;
   logic [AW-1:0] s1_idx_q;
   logic [9:0]    s1_cx_q, s1_cy_q;

   // S2: dot position within the cell, RAM read
   logic [2:0] gx, gy;
   logic [9:0] mx, my;
   logic       area, dot_on;

   always_comb begin
      gx = '0;
      mx = s1_cx_q;
      for (int k = 1; k <= 5; k++)
         if (int'(s1_cx_q) >= k * PIXEL_DIST) begin
            gx = 3'(k);
            mx = s1_cx_q - 10'(k * PIXEL_DIST);
         end
      gy = '0;
      my = s1_cy_q;
      for (int k = 1; k <= 7; k++)
         if (int'(s1_cy_q) >= k * PIXEL_DIST) begin
            gy = 3'(k);
            my = s1_cy_q - 10'(k * PIXEL_DIST);
         end
      // gx==5 or gy==7 means the pixel lies in the inter-cell gap
      area   = (gx < 3'd5) && (gy < 3'd7);
      dot_on = (mx < 10'(PIXEL_LEN)) && (my < 10'(PIXEL_LEN));
   end

   logic       s2_text_q, s2_cursor_q, s2_dot_q, s2_row6_q;
   logic [7:0] s2_code_q;
   logic [5:0] s2_bit_q;

   // S3: glyph bit and colour mux
   glyph_t  glyph;
   logic    lit;
   colour_t colour_q, colour_d;

   vga_glyph_rom u_rom (
      .i_code  (s2_code_q),
      .o_glyph (glyph)
   );

   always_comb begin
      lit      = s2_dot_q && glyph[s2_bit_q];
      colour_d = BLACK;
      if (s2_text_q)
         colour_d = !lit ? BLUE : (s2_code_q == GLY_BLOCK) ? CYAN : WHITE;
      else if (s2_cursor_q)
         colour_d = (cursor_ph && s2_row6_q && s2_dot_q) ? YELLOW : BLUE;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bank_sel_q    <= 1'b0;
         commit_pend_q <= 1'b0;
         active_cnt_q  <= '0;
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < CELLS; i++)
               mem_q[b][i] <= '0;
         s1_text_q   <= 1'b0;
         s1_cursor_q <= 1'b0;
         s1_idx_q    <= '0;
         s1_cx_q     <= '0;
         s1_cy_q     <= '0;
         s2_text_q   <= 1'b0;
         s2_cursor_q <= 1'b0;
         s2_dot_q    <= 1'b0;
         s2_row6_q   <= 1'b0;
         s2_code_q   <= '0;
         s2_bit_q    <= '0;
         colour_q    <= BLACK;
      end else begin
         bank_sel_q    <= bank_sel_d;
         commit_pend_q <= commit_pend_d;
         active_cnt_q  <= active_cnt_d;
         mem_q         <= mem_d;
         s1_text_q     <= in_text_d;
         s1_cursor_q   <= cursor_d;
         s1_idx_q      <= idx[AW-1:0];
         s1_cx_q       <= cx;
         s1_cy_q       <= cy;
         s2_text_q     <= s1_text_q && area;
         s2_cursor_q   <= s1_cursor_q && area;
         s2_dot_q      <= dot_on;
         s2_row6_q     <= (gy == 3'd6);
         s2_code_q     <= mem_q[bank_sel_q][s1_idx_q];
         s2_bit_q      <= 6'(gy) * 6'd5 + 6'(gx);
         colour_q      <= colour_d;
      end
   end

   assign bus.o_Blue  = colour_q[23:16];
   assign bus.o_Green = colour_q[15:8];
   assign bus.o_Red   = colour_q[7:0];
endmodule
